pad_responder: RTL
==================

Name: pad_responder

Overview:
- Off-chip-side counterpart of the chip's PAD command/data interface. Acts as the DRAM-side bridge for the chip.
- Accepts a command beat from the chip, decodes it, then does one of two things:
  - streams PORT_WIDTH beats from a DRAM-like memory to the chip (chip write-TOP), or
  - sinks beats from the chip into memory (chip read-TOP).
- Used as the FPGA/host bridge and as the bench-side DRAM model.

Parameters:
- PORT_WIDTH, 128, pad beat width in bits.
- SRAM_WIDTH, 256, on-chip word width; RATIO = SRAM_WIDTH/PORT_WIDTH must be a power of 2 and ≥1.
- ADDR_WIDTH, 16, width of the ReqNum field in the command.
- DRAM_ADDR_WIDTH, 32, width of the address field in the command.
- MEM_ADDR_WIDTH, 20, memory port address width, in PORT_WIDTH words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ITFPAD_Dat  in  PORT_WIDTH  command/data beat from chip.
- ITFPAD_DatVld  in  1  beat valid.
- ITFPAD_DatLast  in  1  last beat of a command or write burst.
- PADITF_DatRdy  out  1  responder ready for the chip beat.
- PADITF_Dat  out  PORT_WIDTH  read data to chip.
- PADITF_DatVld  out  1  read beat valid.
- PADITF_DatLast  out  1  last read beat.
- ITFPAD_DatRdy  in  1  chip ready for read beat.
- RSPMEM_Addr  out  MEM_ADDR_WIDTH  memory word address.
- RSPMEM_WrEn  out  1  memory write strobe.
- RSPMEM_WrDat  out  PORT_WIDTH  memory write data.
- RSPMEM_RdEn  out  1  memory read strobe; data is valid exactly 1 cycle later.
- MEMRSP_RdDat  in  PORT_WIDTH  memory read data.
- RSP_Busy  out  1  high in any state except IDLE.
- RSP_Err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset: synchronous on rst_n=0 at posedge clk.
  - State goes to IDLE; all outputs 0 except PADITF_DatRdy=1 (IDLE value).
  - Skid FIFO is emptied and counters cleared.
  - Reset mid-burst abandons the burst with no further memory writes.
- Command decode: one beat, handshake ITFPAD_DatVld & PADITF_DatRdy in IDLE. Field layout:
  - bit0 = Dir: 1 = chip sends data, responder writes memory; 0 = chip receives data, responder reads memory.
  - bits[DRAM_ADDR_WIDTH:1] = Addr, in SRAM-word units.
  - bits[DRAM_ADDR_WIDTH+ADDR_WIDTH:DRAM_ADDR_WIDTH+1] = ReqNum, in SRAM words.
  - Upper bits are ignored.
  - ITFPAD_DatLast on the command beat is don't-care.
- Derived values:
  - Beats = ReqNum*RATIO.
  - Base = Addr*RATIO, truncated to MEM_ADDR_WIDTH; wrap-around modulo 2^MEM_ADDR_WIDTH is allowed.
- FSM states: IDLE, DEC, WR, RD, FNH.
- IDLE: PADITF_DatRdy=1; a command handshake latches Base/Beats/Dir and moves to DEC.
- DEC (1 cycle):
  - ReqNum==0: set RSP_Err and go to FNH.
  - Dir=1: go to WR.
  - Dir=0: go to RD.
- WR:
  - PADITF_DatRdy=1.
  - Each handshake drives RSPMEM_WrEn=1 with RSPMEM_Addr=Base+cnt and RSPMEM_WrDat=beat, then increments cnt. Combinational, same cycle as the handshake.
  - Go to FNH on the handshake where cnt==Beats-1.
  - DatLast on that beat is expected; if missing, set RSP_Err.
  - DatLast on an earlier beat: write it, set RSP_Err, go to FNH.
- RD:
  - Reads are issued (RdEn=1, Addr=Base+rcnt) while rcnt<Beats and (FIFO occupancy + in-flight read) < 2.
  - Returned data is pushed into the 2-entry skid FIFO the cycle after RdEn.
  - PADITF_DatVld = FIFO not empty. PADITF_DatLast is high on the beat with ocnt==Beats-1.
  - Vld and Dat are held stable until ITFPAD_DatRdy.
  - Sustained throughput is 1 beat/cycle when ITFPAD_DatRdy is held high.
  - First PADITF_DatVld comes 2 cycles after entering RD.
  - Go to FNH after the last-beat handshake.
- FNH: 1 cycle, PADITF_DatRdy=0, then IDLE.
- PADITF_DatRdy=0 in DEC, RD and FNH.
- Counter widths: ADDR_WIDTH+log2(RATIO). The maximum burst does not overflow.

Optional Feature:
- Macro: RSP_STALL_INJECT_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle.
  - When LFSR[0]=1:
    - In WR, PADITF_DatRdy is forced to 0.
    - In RD, a non-presented FIFO head is held back.
  - Once PADITF_DatVld is high it stays high until its handshake; valid is never retracted.
- When not defined: no LFSR, and no throughput loss beyond what is described above.

Decomposition:
- Shared package pad_pkg:
  - state encoding constants: IDLE/DEC/WR/RD/FNH;
  - command field offsets: CMD_DIR_BIT, CMD_ADDR_LSB, CMD_NUM_LSB;
  - LFSR polynomial and seed.
- The chip-side interface imports the same field offsets.
- One natural sub-module: rsp_skid_fifo, a 2-entry PORT_WIDTH valid/ready FIFO with a count output.

Test Plan:
- Write burst: command Dir=1, Addr=3, ReqNum=2 (RATIO=2), then 4 beats A0..A3 with Last on A3 -> memory words 6..9 = A0..A3; RSP_Err=0; back to IDLE 2 cycles after the last handshake.
- Read burst: preload memory 40..45; command Dir=0, Addr=20, ReqNum=3; ITFPAD_DatRdy=1 -> 6 contiguous beats mem[40..45]; first Vld 2 cycles after entering RD; Last only on the 6th beat.
- Read backpressure: same read with ITFPAD_DatRdy toggling 1,0,0,1,... -> no lost or duplicated beats; Dat stable while Vld & !Rdy; at most 2 reads outstanding.
- Zero-length: command with ReqNum=0 -> no memory access; RSP_Err=1 after DEC; IDLE after FNH.
- Early Last: write burst Beats=4 with Last on beat 2 -> 2 writes; RSP_Err=1; responder accepts the next command.
- Reset mid-RD after the 3rd beat -> all outputs at reset values the next cycle; a subsequent write command completes correctly.

Source files
------------

// File: rtl/pad_pkg.sv
// rtl/pad_pkg.sv - shared state encoding, command field offsets and LFSR constants for the PAD link
// Contents:
//   pad_state_e      responder FSM states IDLE/DEC/WR/RD/FNH
//   CMD_DIR_BIT      direction bit of the command beat
//   CMD_ADDR_LSB     first bit of the Addr field
//   CMD_NUM_LSB      first bit of the ReqNum field for a 32-bit Addr field
//   cmd_num_lsb()    ReqNum offset for any Addr field width
//   LFSR_POLY/SEED   stall-injection LFSR (x^16+x^14+x^13+x^11+1, Galois form)
package pad_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        FNH  = 3'd4
    } pad_state_e;

    localparam int CMD_DIR_BIT             = 0;
    localparam int CMD_ADDR_LSB            = 1;
    localparam int CMD_DEF_DRAM_ADDR_WIDTH = 32;
    localparam int CMD_NUM_LSB             = CMD_ADDR_LSB + CMD_DEF_DRAM_ADDR_WIDTH;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int cmd_num_lsb(input int dram_addr_width);
        return CMD_ADDR_LSB + dram_addr_width;
    endfunction

endpackage

// File: rtl/rsp_skid_fifo.sv
// rtl/rsp_skid_fifo.sv - 2-entry skid FIFO holding memory read data on its way to the chip
// Ports:
//   clk, resetn        clock, synchronous active-low reset (empties the FIFO)
//   s_tdata/s_tvalid   push side; the writer only pushes when it has reserved room
//   m_tdata/m_tvalid   head entry, held stable until popped
//   m_tready           pop when m_tvalid & m_tready
//   count              current occupancy 0..2
module rsp_skid_fifo #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = s_tvalid;
    assign m_tvalid = (r_count != 2'd0);
    assign w_pop    = m_tvalid & m_tready;
    assign m_tdata  = r_mem[r_rd_ptr];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pad_responder.sv
// rtl/pad_responder.sv - DRAM-side responder for the chip PAD command/data interface
// Optional build macro: RSP_STALL_INJECT_EN (LFSR-driven ready/valid stall injection)
// Ports:
//   clk, rst_n                               clock, synchronous active-low reset
//   ITFPAD_Dat/DatVld/DatLast, PADITF_DatRdy command and write beats from the chip
//   PADITF_Dat/DatVld/DatLast, ITFPAD_DatRdy read beats to the chip
//   RSPMEM_Addr/WrEn/WrDat/RdEn, MEMRSP_RdDat memory port, read data one cycle after RdEn
//   RSP_Busy                                 high outside IDLE
//   RSP_Err                                  sticky protocol error
module pad_responder
    import pad_pkg::*;
#(
    parameter int PORT_WIDTH      = 128,
    parameter int SRAM_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 16,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH  = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_WIDTH-1:0]     ITFPAD_Dat,
    input  logic                      ITFPAD_DatVld,
    input  logic                      ITFPAD_DatLast,
    output logic                      PADITF_DatRdy,
    output logic [PORT_WIDTH-1:0]     PADITF_Dat,
    output logic                      PADITF_DatVld,
    output logic                      PADITF_DatLast,
    input  logic                      ITFPAD_DatRdy,
    output logic [MEM_ADDR_WIDTH-1:0] RSPMEM_Addr,
    output logic                      RSPMEM_WrEn,
    output logic [PORT_WIDTH-1:0]     RSPMEM_WrDat,
    output logic                      RSPMEM_RdEn,
    input  logic [PORT_WIDTH-1:0]     MEMRSP_RdDat,
    output logic                      RSP_Busy,
    output logic                      RSP_Err
);

    localparam int RATIO   = SRAM_WIDTH / PORT_WIDTH;
    localparam int LOG2R   = $clog2(RATIO);
    localparam int CW      = ADDR_WIDTH + LOG2R;
    localparam int NUM_LSB = cmd_num_lsb(DRAM_ADDR_WIDTH);
    localparam int CMD_TOP = NUM_LSB + ADDR_WIDTH;

    pad_state_e                r_state, w_next;
    logic [MEM_ADDR_WIDTH-1:0] r_base;
    logic [CW-1:0]             r_beats, r_cnt, r_rcnt, r_ocnt;
    logic                      r_dir, r_rd_pend, r_err;
    logic                      w_cmd_hs, w_set_err, w_stall, w_hold;
    logic                      w_out_vld, w_pop, w_room, w_fifo_vld, w_fifo_rdy;
    logic                      w_wr_last, w_rd_last;
    logic [PORT_WIDTH-1:0]     w_fifo_dat;
    logic [1:0]                w_fifo_cnt;
    logic [MEM_ADDR_WIDTH-1:0] w_cmd_addr;
    logic [ADDR_WIDTH-1:0]     w_cmd_num;
    logic                      w_unused;

    // Only the low MEM_ADDR_WIDTH address bits matter: Base wraps modulo the memory size.
    assign w_cmd_addr = ITFPAD_Dat[CMD_ADDR_LSB +: MEM_ADDR_WIDTH];
    assign w_cmd_num  = ITFPAD_Dat[NUM_LSB +: ADDR_WIDTH];
    assign w_unused   = &{1'b0, ITFPAD_Dat[PORT_WIDTH-1:CMD_TOP],
                          ITFPAD_Dat[NUM_LSB-1:CMD_ADDR_LSB+MEM_ADDR_WIDTH]};

`ifdef RSP_STALL_INJECT_EN
    logic [15:0] r_lfsr;
    logic        r_shown;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr  <= LFSR_SEED;
            r_shown <= 1'b0;
        end else begin
            r_lfsr  <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
            r_shown <= w_out_vld & ~ITFPAD_DatRdy;
        end
    end

    assign w_stall = r_lfsr[0];
    // A head already presented to the chip is never withdrawn.
    assign w_hold  = w_stall & ~r_shown;
`else
    assign w_stall = 1'b0;
    assign w_hold  = 1'b0;
`endif

    assign w_cmd_hs   = (r_state == IDLE) & ITFPAD_DatVld;
    assign w_out_vld  = (r_state == RD) & w_fifo_vld & ~w_hold;
    assign w_fifo_rdy = (r_state == RD) & ITFPAD_DatRdy & ~w_hold;
    assign w_pop      = w_out_vld & ITFPAD_DatRdy;
    assign w_wr_last  = (r_cnt == r_beats - CW'(1));
    assign w_rd_last  = (r_ocnt == r_beats - CW'(1));
    // Counting this cycle's pop as free space keeps the FIFO streaming at one beat per cycle.
    assign w_room     = ({1'b0, w_fifo_cnt} + {2'b00, r_rd_pend}) <= (3'd1 + {2'b00, w_pop});

    assign PADITF_DatVld  = w_out_vld;
    assign PADITF_DatLast = w_out_vld & w_rd_last;
    assign PADITF_Dat     = w_out_vld ? w_fifo_dat : '0;
    assign RSP_Busy       = (r_state != IDLE);
    assign RSP_Err        = r_err;

    rsp_skid_fifo #(.WIDTH(PORT_WIDTH)) u_skid (
        .clk      (clk),
        .resetn   (rst_n),
        .s_tdata  (MEMRSP_RdDat),
        .s_tvalid (r_rd_pend),
        .m_tdata  (w_fifo_dat),
        .m_tvalid (w_fifo_vld),
        .m_tready (w_fifo_rdy),
        .count    (w_fifo_cnt)
    );

    always_comb begin
        w_next        = r_state;
        PADITF_DatRdy = 1'b0;
        RSPMEM_WrEn   = 1'b0;
        RSPMEM_RdEn   = 1'b0;
        RSPMEM_Addr   = '0;
        RSPMEM_WrDat  = '0;
        w_set_err     = 1'b0;
        case (r_state)
            IDLE: begin
                PADITF_DatRdy = 1'b1;
                if (ITFPAD_DatVld) w_next = DEC;
            end
            DEC: begin
                if (r_beats == '0) begin
                    w_set_err = 1'b1;
                    w_next    = FNH;
                end else if (r_dir) begin
                    w_next = WR;
                end else begin
                    w_next = RD;
                end
            end
            WR: begin
                PADITF_DatRdy = ~w_stall;
                if (ITFPAD_DatVld && !w_stall) begin
                    RSPMEM_WrEn  = 1'b1;
                    RSPMEM_Addr  = r_base + MEM_ADDR_WIDTH'(r_cnt);
                    RSPMEM_WrDat = ITFPAD_Dat;
                    if (w_wr_last) begin
                        w_next    = FNH;
                        w_set_err = ~ITFPAD_DatLast;
                    end else if (ITFPAD_DatLast) begin
                        w_next    = FNH;
                        w_set_err = 1'b1;
                    end
                end
            end
            RD: begin
                if ((r_rcnt < r_beats) && w_room) begin
                    RSPMEM_RdEn = 1'b1;
                    RSPMEM_Addr = r_base + MEM_ADDR_WIDTH'(r_rcnt);
                end
                if (w_pop && w_rd_last) w_next = FNH;
            end
            FNH:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_beats   <= '0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
            r_rcnt    <= '0;
            r_ocnt    <= '0;
            r_rd_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= RSPMEM_RdEn;
            if (w_set_err) r_err <= 1'b1;
            if (w_cmd_hs) begin
                r_dir   <= ITFPAD_Dat[CMD_DIR_BIT];
                r_base  <= w_cmd_addr << LOG2R;
                r_beats <= CW'(w_cmd_num) << LOG2R;
                r_cnt   <= '0;
                r_rcnt  <= '0;
                r_ocnt  <= '0;
            end else begin
                if (RSPMEM_WrEn) r_cnt  <= r_cnt + CW'(1);
                if (RSPMEM_RdEn) r_rcnt <= r_rcnt + CW'(1);
                if (w_pop)       r_ocnt <= r_ocnt + CW'(1);
            end
        end
    end

endmodule
